// File: rtl/team_06_pkg.sv
// Shared types and constants for the microphone gain sequencer.
package team_06_pkg;

  localparam int GAIN_W   = 8;
  localparam int GAIN_MAX = 240;

  typedef enum logic [1:0] {
    SILENT   = 2'd0,
    FADE_IN  = 2'd1,
    OPEN     = 2'd2,
    FADE_OUT = 2'd3
  } gain_state_t;

endpackage

// File: rtl/team_06_gate_hold.sv
// Noise-gate hold timer: keeps the gate open for NG_HOLD samples after the
// level detector last reported signal above threshold.
module team_06_gate_hold #(
  parameter int unsigned NG_HOLD = 2400
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_strobe,
  input  logic noise_gate,
  input  logic ng_open,
  output logic gate_ok
);

  localparam logic [15:0] HOLD_INIT = 16'(NG_HOLD);

  logic [15:0] hold_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (sample_strobe) begin
      if (ng_open)
        hold_cnt <= HOLD_INIT;
      else if (hold_cnt != '0)
        hold_cnt <= hold_cnt - 16'd1;
    end
  end

  assign gate_ok = ~noise_gate | ng_open | (hold_cnt != '0);

endmodule

// File: rtl/team_06_gain_sequencer.sv
// Click-free gain sequencer: ramps the applied gain one step per sample and
// defers effect switching until the audio path is silent.
module team_06_gain_sequencer
  import team_06_pkg::*;
#(
  parameter int unsigned RAMP_STEP    = 1,
  parameter int unsigned NG_HOLD      = 2400,
  parameter int unsigned PTT_REQUIRED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_strobe,
  input  logic [3:0]        volume,
  input  logic              mute,
  input  logic              ptt,
  input  logic              noise_gate,
  input  logic              ng_open,
  input  logic              effect,
  output logic [GAIN_W-1:0] gain,
  output logic              path_en,
  output logic              effect_en,
  output logic [1:0]        state
);

  localparam logic [GAIN_W:0] STEP_EXT = (GAIN_W + 1)'(RAMP_STEP);
  localparam logic            PTT_OFF  = (PTT_REQUIRED == 0);

  gain_state_t       state_q, state_nxt;
  logic [GAIN_W-1:0] gain_q, gain_nxt, stepped, faded;
  logic [GAIN_W-1:0] target;
  logic              gate_ok, audible;
  logic              path_en_q, effect_en_q;

  // Saturating step up, never passing lim.
  function automatic logic [GAIN_W-1:0] sat_up(input logic [GAIN_W-1:0] g,
                                               input logic [GAIN_W-1:0] lim);
    logic [GAIN_W:0] sum;
    sum = {1'b0, g} + STEP_EXT;
    return (sum >= {1'b0, lim}) ? lim : sum[GAIN_W-1:0];
  endfunction

  // Saturating step down in 9-bit signed, never passing lim.
  function automatic logic [GAIN_W-1:0] sat_down(input logic [GAIN_W-1:0] g,
                                                 input logic [GAIN_W-1:0] lim);
    logic signed [GAIN_W:0] diff;
    diff = $signed({1'b0, g}) - $signed(STEP_EXT);
    return (diff <= $signed({1'b0, lim})) ? lim : diff[GAIN_W-1:0];
  endfunction

  function automatic logic [GAIN_W-1:0] step_toward(input logic [GAIN_W-1:0] g,
                                                    input logic [GAIN_W-1:0] t);
    if (g < t)      return sat_up(g, t);
    else if (g > t) return sat_down(g, t);
    else            return g;
  endfunction

  team_06_gate_hold #(.NG_HOLD(NG_HOLD)) u_gate_hold (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .noise_gate    (noise_gate),
    .ng_open       (ng_open),
    .gate_ok       (gate_ok)
  );

  assign target  = {volume, 4'b0000};
  assign audible = ~mute & (ptt | PTT_OFF) & gate_ok;
  assign stepped = step_toward(gain_q, target);
  assign faded   = sat_down(gain_q, '0);

  // Transition strobes hold the gain; the new state's ramp starts next strobe.
  always_comb begin
    state_nxt = state_q;
    gain_nxt  = gain_q;
    unique case (state_q)
      SILENT: begin
        gain_nxt = '0;
        if (audible) state_nxt = FADE_IN;
      end
      FADE_IN: begin
        if (!audible) begin
          state_nxt = FADE_OUT;
        end else begin
          gain_nxt = stepped;
          if (stepped == target) state_nxt = OPEN;
        end
      end
      OPEN: begin
        if (!audible) state_nxt = FADE_OUT;
        else          gain_nxt  = stepped;
      end
      FADE_OUT: begin
        if (audible) begin
          state_nxt = FADE_IN;
        end else begin
          gain_nxt = faded;
          if (faded == '0) state_nxt = SILENT;
        end
      end
    endcase
  end

  // Registered outputs, updated only on sample strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SILENT;
      gain_q      <= '0;
      path_en_q   <= 1'b0;
      effect_en_q <= 1'b0;
    end else if (sample_strobe) begin
      state_q   <= state_nxt;
      gain_q    <= gain_nxt;
      path_en_q <= (state_nxt != SILENT);
      if (state_q == SILENT) effect_en_q <= effect;
    end
  end

  assign gain      = gain_q;
  assign path_en   = path_en_q;
  assign effect_en = effect_en_q;
  assign state     = state_q;

endmodule

// File: tb/tb_team_06_gain_sequencer.sv
// Directed bench for the gain sequencer with hand-computed expectations.
module tb_team_06_gain_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_strobe;
  logic [3:0] volume;
  logic       mute, ptt, noise_gate, ng_open, effect;
  logic [7:0] gain;
  logic       path_en, effect_en;
  logic [1:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [1:0] S_SILENT = 2'd0, S_FADE_IN = 2'd1, S_OPEN = 2'd2, S_FADE_OUT = 2'd3;

  team_06_gain_sequencer #(.RAMP_STEP(1), .NG_HOLD(4), .PTT_REQUIRED(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .volume        (volume),
    .mute          (mute),
    .ptt           (ptt),
    .noise_gate    (noise_gate),
    .ng_open       (ng_open),
    .effect        (effect),
    .gain          (gain),
    .path_en       (path_en),
    .effect_en     (effect_en),
    .state         (state)
  );

  always #20 clk = ~clk;

  // n back-to-back strobe cycles; returns at a negedge with outputs settled.
  task automatic strobe(input int n);
    sample_strobe = 1'b1;
    repeat (n) @(negedge clk);
    sample_strobe = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sample_strobe = 1'b0; volume = 4'd15; mute = 1'b0; ptt = 1'b1;
    noise_gate = 1'b0; ng_open = 1'b0; effect = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (gain !== 8'd0) begin $display("FAIL reset_gain got %0d want 0", gain); n_fail++; end
    n_cmp++; if (path_en !== 1'b0) begin $display("FAIL reset_path_en got %b want 0", path_en); n_fail++; end
    n_cmp++; if (state !== S_SILENT) begin $display("FAIL reset_state got %0d want 0", state); n_fail++; end
    n_cmp++; if (effect_en !== 1'b0) begin $display("FAIL reset_effect_en got %b want 0", effect_en); n_fail++; end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (gain !== 8'd0 || state !== S_SILENT) begin
      $display("FAIL idle_no_strobe gain=%0d state=%0d want 0/0", gain, state); n_fail++; end
  endtask

  task automatic test_ramp_up;
    strobe(1);
    n_cmp++; if (path_en !== 1'b1) begin $display("FAIL entry_path_en got %b want 1", path_en); n_fail++; end
    n_cmp++; if (gain !== 8'd0) begin $display("FAIL entry_gain got %0d want 0", gain); n_fail++; end
    n_cmp++; if (state !== S_FADE_IN) begin $display("FAIL entry_state got %0d want 1", state); n_fail++; end
    for (int i = 1; i <= 239; i++) begin
      strobe(1);
      n_cmp++; if (gain !== 8'(i) || state !== S_FADE_IN) begin
        $display("FAIL ramp_up_step%0d gain=%0d state=%0d want %0d/1", i, gain, state, i); n_fail++; end
    end
    strobe(1);
    n_cmp++; if (gain !== 8'd240) begin $display("FAIL ramp_up_final got %0d want 240", gain); n_fail++; end
    n_cmp++; if (state !== S_OPEN) begin $display("FAIL ramp_up_open got %0d want 2", state); n_fail++; end
  endtask

  task automatic test_volume;
    volume = 4'd8;
    for (int i = 1; i <= 112; i++) begin
      strobe(1);
      n_cmp++; if (gain !== 8'(240 - i) || state !== S_OPEN) begin
        $display("FAIL vol_down_step%0d gain=%0d state=%0d want %0d/2", i, gain, state, 240 - i); n_fail++; end
    end
    strobe(1);
    n_cmp++; if (gain !== 8'd128) begin $display("FAIL vol_down_hold got %0d want 128", gain); n_fail++; end
    volume = 4'd10;
    strobe(32);
    n_cmp++; if (gain !== 8'd160 || state !== S_OPEN) begin
      $display("FAIL vol_up gain=%0d state=%0d want 160/2", gain, state); n_fail++; end
    strobe(1);
    n_cmp++; if (gain !== 8'd160) begin $display("FAIL vol_up_hold got %0d want 160", gain); n_fail++; end
  endtask

  task automatic test_mute;
    mute = 1'b1;
    strobe(1);
    n_cmp++; if (state !== S_FADE_OUT || gain !== 8'd160) begin
      $display("FAIL mute_enter state=%0d gain=%0d want 3/160", state, gain); n_fail++; end
    for (int i = 1; i <= 80; i++) begin
      strobe(1);
      n_cmp++; if (gain !== 8'(160 - i)) begin
        $display("FAIL fade_out_step%0d got %0d want %0d", i, gain, 160 - i); n_fail++; end
    end
    mute = 1'b0;
    strobe(1);
    n_cmp++; if (state !== S_FADE_IN || gain !== 8'd80) begin
      $display("FAIL unmute state=%0d gain=%0d want 1/80", state, gain); n_fail++; end
    strobe(1);
    n_cmp++; if (gain !== 8'd81) begin $display("FAIL unmute_resume got %0d want 81", gain); n_fail++; end
    strobe(79);
    n_cmp++; if (state !== S_OPEN || gain !== 8'd160) begin
      $display("FAIL refade_open state=%0d gain=%0d want 2/160", state, gain); n_fail++; end
    mute = 1'b1;
    strobe(160);
    n_cmp++; if (gain !== 8'd1 || path_en !== 1'b1 || state !== S_FADE_OUT) begin
      $display("FAIL fade_out_last gain=%0d path=%b state=%0d want 1/1/3", gain, path_en, state); n_fail++; end
    strobe(1);
    n_cmp++; if (gain !== 8'd0 || path_en !== 1'b0 || state !== S_SILENT) begin
      $display("FAIL fade_out_silent gain=%0d path=%b state=%0d want 0/0/0", gain, path_en, state); n_fail++; end
  endtask

  task automatic test_effect;
    volume = 4'd1; mute = 1'b0;
    strobe(17);
    n_cmp++; if (state !== S_OPEN || gain !== 8'd16) begin
      $display("FAIL fx_open state=%0d gain=%0d want 2/16", state, gain); n_fail++; end
    effect = 1'b1;
    strobe(3);
    n_cmp++; if (effect_en !== 1'b0) begin $display("FAIL fx_open_deferred got %b want 0", effect_en); n_fail++; end
    mute = 1'b1;
    strobe(17);
    n_cmp++; if (state !== S_SILENT || effect_en !== 1'b0) begin
      $display("FAIL fx_enter_silent state=%0d fx=%b want 0/0", state, effect_en); n_fail++; end
    strobe(1);
    n_cmp++; if (effect_en !== 1'b1) begin $display("FAIL fx_applied got %b want 1", effect_en); n_fail++; end
    effect = 1'b0;
    strobe(1);
    n_cmp++; if (effect_en !== 1'b0) begin $display("FAIL fx_cleared got %b want 0", effect_en); n_fail++; end
  endtask

  task automatic test_target_zero;
    volume = 4'd0; mute = 1'b0;
    strobe(1);
    n_cmp++; if (state !== S_FADE_IN || path_en !== 1'b1) begin
      $display("FAIL zero_entry state=%0d path=%b want 1/1", state, path_en); n_fail++; end
    strobe(1);
    n_cmp++; if (state !== S_OPEN || gain !== 8'd0 || path_en !== 1'b1) begin
      $display("FAIL zero_open state=%0d gain=%0d path=%b want 2/0/1", state, gain, path_en); n_fail++; end
    ptt = 1'b0;
    strobe(1);
    n_cmp++; if (state !== S_FADE_OUT) begin $display("FAIL ptt_release got %0d want 3", state); n_fail++; end
    strobe(1);
    n_cmp++; if (state !== S_SILENT || path_en !== 1'b0) begin
      $display("FAIL ptt_silent state=%0d path=%b want 0/0", state, path_en); n_fail++; end
    strobe(2);
    n_cmp++; if (state !== S_SILENT) begin $display("FAIL ptt_stay_silent got %0d want 0", state); n_fail++; end
    ptt = 1'b1;
  endtask

  task automatic test_gate;
    volume = 4'd1; noise_gate = 1'b1; ng_open = 1'b0;
    strobe(2);
    n_cmp++; if (state !== S_SILENT) begin $display("FAIL gate_closed got %0d want 0", state); n_fail++; end
    ng_open = 1'b1;
    strobe(1);
    n_cmp++; if (state !== S_FADE_IN) begin $display("FAIL gate_opens got %0d want 1", state); n_fail++; end
    ng_open = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      strobe(1);
      n_cmp++; if (state !== S_FADE_IN || gain !== 8'(i)) begin
        $display("FAIL gate_hold%0d state=%0d gain=%0d want 1/%0d", i, state, gain, i); n_fail++; end
    end
    strobe(1);
    n_cmp++; if (state !== S_FADE_OUT || gain !== 8'd4) begin
      $display("FAIL gate_expire state=%0d gain=%0d want 3/4", state, gain); n_fail++; end
    strobe(4);
    n_cmp++; if (state !== S_SILENT || gain !== 8'd0) begin
      $display("FAIL gate_silent state=%0d gain=%0d want 0/0", state, gain); n_fail++; end
    noise_gate = 1'b0;
  endtask

  task automatic test_back_to_back;
    volume = 4'd15;
    strobe(1);
    strobe(5);
    n_cmp++; if (gain !== 8'd5) begin $display("FAIL held_strobe got %0d want 5", gain); n_fail++; end
    repeat (3) @(negedge clk);
    n_cmp++; if (gain !== 8'd5) begin $display("FAIL no_strobe_hold got %0d want 5", gain); n_fail++; end
    strobe(95);
    n_cmp++; if (gain !== 8'd100 || state !== S_FADE_IN) begin
      $display("FAIL pre_reset gain=%0d state=%0d want 100/1", gain, state); n_fail++; end
    sample_strobe = 1'b1;
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    n_cmp++; if (gain !== 8'd0 || path_en !== 1'b0 || state !== S_SILENT) begin
      $display("FAIL async_reset gain=%0d path=%b state=%0d want 0/0/0", gain, path_en, state); n_fail++; end
    sample_strobe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    strobe(1);
    n_cmp++; if (state !== S_FADE_IN || gain !== 8'd0 || path_en !== 1'b1) begin
      $display("FAIL post_reset state=%0d gain=%0d path=%b want 1/0/1", state, gain, path_en); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_volume();
    test_mute();
    test_effect();
    test_target_zero();
    test_gate();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
